gray_burst_sched: RTL and testbench

- Controller and scheduler for the team's shared Gray-code counter datapath.
- Two requesters issue commands through valid/ready ports: clear, load, count-up burst or count-down burst.
- A round-robin arbiter grants one requester at a time.
- A small FSM sequences the internal binary counter and drives a registered Gray-coded output, a busy flag and a done pulse.

---
 rtl/gray_sched_pkg.sv | 30 +++
 rtl/gray_burst_sched_rr_arb2.sv | 43 ++++
 rtl/gray_burst_sched.sv | 181 ++++++++++++++++++
 tb/tb_gray_burst_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_sched_pkg.sv
// rtl/gray_sched_pkg.sv - shared types and helpers for gray_burst_sched
//
// Purpose: opcode and FSM state encodings plus the binary-to-Gray helper
//          used by the scheduler.
// Ports:   none (package).
package gray_sched_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'b00,
    OP_LOAD   = 2'b01,
    OP_RUN_UP = 2'b10,
    OP_RUN_DN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int GRAY_MAX_W = 32;

  // Works for any counter width up to GRAY_MAX_W: callers zero-extend into
  // the wide argument and cast the result back to their own width. The zero
  // fill makes the top Gray bit equal the top binary bit, as required.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_burst_sched_rr_arb2.sv
// rtl/gray_burst_sched_rr_arb2.sv - two-request round-robin arbiter
//
// Purpose: grants one of two requesters; on a tie the requester that did not
//          win the most recent accepted grant wins.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req[1:0]    request lines (valid from each requester)
//   accept      the current grant was taken this cycle; advances the pointer
//   grant[1:0]  one-hot grant, combinational from req and the pointer
//   ptr         index of the last accepted winner
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       ptr
);

  logic r_last;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset value 1 makes requester 0 the winner of the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (accept) begin
      r_last <= grant[1];
    end
  end

  assign ptr = r_last;

endmodule

// File: rtl/gray_burst_sched.sv
// rtl/gray_burst_sched.sv - two-requester command scheduler for the Gray counter
//
// Purpose: accepts clear/load/count-up/count-down commands from two
//          round-robin arbitrated requesters and sequences a binary counter
//          whose Gray code is presented on a register.
// Optional: define GRAY_SCHED_ABORT_EN to add the abort input and aborted
//           output; without it every burst runs its full length.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   reqN_valid/ready        command handshake for requester N (N = 0, 1)
//   reqN_op, reqN_arg       opcode and argument (load value or burst length)
//   abort, aborted          (GRAY_SCHED_ABORT_EN only) stop a burst early
//   gray_out                registered Gray code of the internal count
//   busy                    a command is executing
//   done                    one-cycle pulse when a command completes
//   owner                   requester whose command was last accepted
module gray_burst_sched
  import gray_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_arg,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_arg,
`ifdef GRAY_SCHED_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [WIDTH-1:0] gray_out,
  output logic             busy,
  output logic             done,
  output logic             owner
);

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              r_op;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] r_rem;
  logic             r_done;
  logic             r_seen;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic [1:0]       w_grant;
  logic             w_ptr;
  logic             w_idle;
  logic             w_accept;
  logic             w_abort;
  op_e              w_cmd_op;
  logic [WIDTH-1:0] w_cmd_arg;

  assign w_idle = (r_state == IDLE);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .accept (w_accept),
    .grant  (w_grant),
    .ptr    (w_ptr)
  );

  assign req0_ready = w_idle & w_grant[0];
  assign req1_ready = w_idle & w_grant[1];
  // A grant is only ever given to a valid requester, so ready alone means accept.
  assign w_accept   = req0_ready | req1_ready;
  assign w_cmd_op   = op_e'(w_grant[1] ? req1_op : req0_op);
  assign w_cmd_arg  = w_grant[1] ? req1_arg : req0_arg;

`ifdef GRAY_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // r_rem doubles as the latched load value for LOAD, applied in FIN.
  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if ((w_cmd_op == OP_RUN_UP || w_cmd_op == OP_RUN_DN) && (w_cmd_arg != '0)) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = FIN;
          end
        end
      end
      RUN: begin
        if (w_abort) begin
          w_state_nxt = FIN;
        end else begin
          w_bin_nxt = (r_op == OP_RUN_DN) ? (r_bin - WIDTH'(1)) : (r_bin + WIDTH'(1));
          if (r_rem == WIDTH'(1)) begin
            w_state_nxt = FIN;
          end
        end
      end
      FIN: begin
        if (r_op == OP_CLEAR) begin
          w_bin_nxt = '0;
        end else if (r_op == OP_LOAD) begin
          w_bin_nxt = r_rem;
        end
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Gray register is loaded from the next binary value so it never lags.
  assign w_gray_nxt = WIDTH'(bin2gray(GRAY_MAX_W'(w_bin_nxt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= OP_CLEAR;
      r_bin   <= '0;
      r_gray  <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_seen  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_gray  <= w_gray_nxt;
      // Registered from FIN so done lines up with the cycle the FSM is back in IDLE.
      r_done  <= (r_state == FIN);
      if (w_accept) begin
        r_op   <= w_cmd_op;
        r_rem  <= w_cmd_arg;
        r_seen <= 1'b1;
      end else if (r_state == RUN && !w_abort) begin
        r_rem <= r_rem - WIDTH'(1);
      end
    end
  end

`ifdef GRAY_SCHED_ABORT_EN
  logic r_abort_pend;
  logic r_aborted;

  // The abort is remembered through FIN so aborted rises together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
    end else if (w_accept) begin
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      if (r_state == RUN && abort) begin
        r_abort_pend <= 1'b1;
      end
      if (r_state == FIN && r_abort_pend) begin
        r_aborted    <= 1'b1;
        r_abort_pend <= 1'b0;
      end
    end
  end

  assign aborted = r_aborted;
`endif

  assign gray_out = r_gray;
  assign busy     = ~w_idle;
  assign done     = r_done;
  // The arbiter pointer resets to 1 for tie priority; owner must read 0 until
  // something has actually been accepted.
  assign owner    = r_seen & w_ptr;

endmodule

// File: tb/tb_gray_burst_sched.sv
// tb/tb_gray_burst_sched.sv - self-checking bench for gray_burst_sched
module tb_gray_burst_sched;

  localparam int W = 8;
  localparam logic [1:0] CLR = 2'b00;
  localparam logic [1:0] LD  = 2'b01;
  localparam logic [1:0] UP  = 2'b10;
  localparam logic [1:0] DN  = 2'b11;
`ifdef GRAY_SCHED_ABORT_EN
  localparam bit ABORT_BUILD = 1'b1;
`else
  localparam bit ABORT_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req1_valid = 1'b0;
  logic [1:0]   req0_op = 2'b00;
  logic [1:0]   req1_op = 2'b00;
  logic [W-1:0] req0_arg = '0;
  logic [W-1:0] req1_arg = '0;
  logic         tb_abort = 1'b0;
  logic         req0_ready;
  logic         req1_ready;
  logic [W-1:0] gray_out;
  logic         busy;
  logic         done;
  logic         owner;
`ifdef GRAY_SCHED_ABORT_EN
  logic         aborted;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gray_burst_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_arg   (req0_arg),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_arg   (req1_arg),
`ifdef GRAY_SCHED_ABORT_EN
    .abort      (tb_abort),
    .aborted    (aborted),
`endif
    .gray_out   (gray_out),
    .busy       (busy),
    .done       (done),
    .owner      (owner)
  );

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
    end
  endfunction

  // Behavioural model: a command is a number of busy cycles, a number of
  // count steps and an optional value applied when the steps run out.
  int m_bin, m_busy_left, m_steps, m_dir, m_pend_val, m_last;
  bit m_pend, m_done, m_owner, m_aborted, m_abt_pend, m_acc0, m_acc1;

  function automatic int gray_of(int b);
    return (b ^ (b >> 1)) & 255;
  endfunction

  function automatic logic [1:0] exp_grant();
    if (req0_valid && req1_valid) return (m_last == 0) ? 2'b10 : 2'b01;
    return {req1_valid, req0_valid};
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [1:0] gr;
    bit nd, ab, idx;
    int op, arg;
    if (!rst_n) begin
      m_bin = 0; m_busy_left = 0; m_steps = 0; m_dir = 1; m_pend = 0; m_pend_val = 0;
      m_done = 0; m_last = -1; m_owner = 0; m_aborted = 0; m_abt_pend = 0;
      m_acc0 = 0; m_acc1 = 0;
    end else begin
      gr = exp_grant();
      ab = tb_abort & ABORT_BUILD;
      nd = 0; m_acc0 = 0; m_acc1 = 0;
      if (m_busy_left > 0) begin
        if (ab && m_steps > 0) begin
          m_steps = 0; m_busy_left = 1; m_abt_pend = 1;
        end else begin
          if (m_steps > 0) begin
            m_bin = (m_bin + m_dir) & 255; m_steps--;
          end else if (m_pend) begin
            m_bin = m_pend_val; m_pend = 0;
          end
          m_busy_left--;
          if (m_busy_left == 0) begin
            nd = 1;
            if (m_abt_pend) m_aborted = 1;
            m_abt_pend = 0;
          end
        end
      end else if (gr != 2'b00) begin
        idx = gr[1];
        m_last = idx; m_owner = idx; m_aborted = 0; m_abt_pend = 0;
        op  = idx ? req1_op : req0_op;
        arg = idx ? req1_arg : req0_arg;
        if (op == CLR || op == LD) begin
          m_pend = 1; m_pend_val = (op == CLR) ? 0 : arg; m_steps = 0; m_busy_left = 1;
        end else begin
          m_pend = 0; m_steps = arg; m_dir = (op == UP) ? 1 : -1; m_busy_left = arg + 1;
        end
        if (idx) m_acc1 = 1; else m_acc0 = 1;
      end
      m_done = nd;
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0] gr;
    if (rst_n) begin
      gr = exp_grant();
      chk("gray_out", gray_out, gray_of(m_bin));
      chk("busy", busy, m_busy_left != 0);
      chk("done", done, m_done);
      chk("owner", owner, m_owner);
      chk("req0_ready", req0_ready, (m_busy_left == 0) && gr[0]);
      chk("req1_ready", req1_ready, (m_busy_left == 0) && gr[1]);
`ifdef GRAY_SCHED_ABORT_EN
      chk("aborted", aborted, m_aborted);
`endif
    end
  end

  task automatic send(input bit idx, input logic [1:0] op, input logic [W-1:0] arg);
    bit ok = 0;
    @(posedge clk); #2;
    if (idx) begin req1_valid = 1; req1_op = op; req1_arg = arg; end
    else begin req0_valid = 1; req0_op = op; req0_arg = arg; end
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      ok = idx ? m_acc1 : m_acc0;
    end
    #1;
    if (idx) req1_valid = 0; else req0_valid = 0;
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout req=%0d got=no_accept exp=accept", idx);
    end
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((m_busy_left != 0 || m_done) && i < 400) begin
      @(negedge clk); i++;
    end
    if (i >= 400) begin
      n_checks++; n_errors++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin : stim
    int bc, dc;
    int seq[$];

    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    // Reset / idle state.
    @(negedge clk);
    chk("rst_gray", gray_out, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_owner", owner, 0);
    #1 req0_valid = 1;
    #1 chk("rst_ready0", req0_ready, 1);
    req0_valid = 0;

    // LOAD 0x7F then RUN_UP 2.
    send(0, LD, 8'h7F);
    @(negedge clk);
    @(negedge clk);
    chk("load7f_gray", gray_out, 8'h40);
    chk("load7f_done", done, 1);
    send(0, UP, 8'd2);
    bc = 0; dc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dc++;
      if (k == 0) chk("up2_k0_gray", gray_out, 8'h40);
      if (k == 1) chk("up2_k1_gray", gray_out, 8'hC0);
      if (k == 2) chk("up2_k2_gray", gray_out, 8'hC1);
    end
    chk("up2_busy_cycles", bc, 3);
    chk("up2_done_pulses", dc, 1);

    // Wrap up and down.
    send(0, LD, 8'hFF);
    repeat (2) @(negedge clk);
    send(0, UP, 8'd1);
    repeat (2) @(negedge clk);
    chk("wrap_up_gray", gray_out, 8'h00);
    send(0, CLR, 8'h55);
    repeat (2) @(negedge clk);
    chk("clear_gray", gray_out, 8'h00);
    send(0, DN, 8'd1);
    repeat (2) @(negedge clk);
    chk("wrap_dn_gray", gray_out, 8'h80);

    // RUN_UP 0 from 0x05.
    send(0, LD, 8'h05);
    repeat (2) @(negedge clk);
    send(0, UP, 8'd0);
    @(negedge clk);
    chk("up0_k0_gray", gray_out, 8'h07);
    chk("up0_k0_done", done, 0);
    @(negedge clk);
    chk("up0_k1_gray", gray_out, 8'h07);
    chk("up0_k1_done", done, 1);

    // Both requesters always valid: accepts alternate starting with 1.
    wait_idle();
    @(posedge clk); #2;
    req0_valid = 1; req0_op = UP; req0_arg = 8'd1;
    req1_valid = 1; req1_op = UP; req1_arg = 8'd1;
    for (int i = 0; i < 40 && seq.size() < 4; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) seq.push_back(0);
      if (req1_valid && req1_ready) seq.push_back(1);
    end
    @(posedge clk); #2;
    req0_valid = 0; req1_valid = 0;
    chk("alt_count", seq.size(), 4);
    if (seq.size() >= 4) begin
      chk("alt_0", seq[0], 1);
      chk("alt_1", seq[1], 0);
      chk("alt_2", seq[2], 1);
      chk("alt_3", seq[3], 0);
    end
    wait_idle();
    chk("alt_owner", owner, 0);

`ifdef GRAY_SCHED_ABORT_EN
    // Abort after three steps of RUN_UP 10 from 0x10: count stays at 0x13.
    send(0, LD, 8'h10);
    repeat (2) @(negedge clk);
    send(0, UP, 8'd10);
    repeat (3) @(posedge clk);
    #2 tb_abort = 1;
    @(posedge clk);
    #2 tb_abort = 0;
    @(negedge clk);
    chk("abort_k0_gray", gray_out, 8'h1A);
    chk("abort_k0_done", done, 0);
    @(negedge clk);
    chk("abort_k1_gray", gray_out, 8'h1A);
    chk("abort_k1_done", done, 1);
    chk("abort_k1_aborted", aborted, 1);
    wait_idle();
`endif

    // Reset in the middle of a long burst from requester 1.
    send(1, UP, 8'd200);
    repeat (5) @(negedge clk);
    chk("pre_rst_owner", owner, 1);
    #3 rst_n = 0;
    #1;
    chk("midrst_gray", gray_out, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_owner", owner, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if (!(req0_valid && !m_acc0)) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op    = 2'($urandom_range(0, 3));
        req0_arg   = req0_op[1] ? 8'($urandom_range(0, 5)) : 8'($urandom);
      end
      if (!(req1_valid && !m_acc1)) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op    = 2'($urandom_range(0, 3));
        req1_arg   = req1_op[1] ? 8'($urandom_range(0, 5)) : 8'($urandom);
      end
      tb_abort = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #2;
    req0_valid = 0; req1_valid = 0; tb_abort = 0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
